// File: rtl/sprite_blitter_if.sv
// Command, drawer-handshake and sprite-ROM signals of sprite_blitter.
// master = game logic / drawer / ROM side, slave = the blitter.
interface sprite_blitter_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_x;
   logic [8:0]  cmd_y;
   logic [5:0]  cmd_w;
   logic [5:0]  cmd_h;
   logic [15:0] cmd_base;
   logic        cmd_flip;
   logic        blitterStart;
   logic        ackBack;
   logic        enable;
   logic        acknowladge;
   logic        busy;
   logic [15:0] rom_addr;
   logic [15:0] rom_data;

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_base, cmd_flip,
      output blitterStart, acknowladge, rom_data,
      input  cmd_ready, ackBack, enable, busy, rom_addr
   );

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_base, cmd_flip,
      input  blitterStart, acknowladge, rom_data,
      output cmd_ready, ackBack, enable, busy, rom_addr
   );
endinterface

// File: rtl/sprite_blitter.sv
// Queues sprite draw commands and copies sprites from ROM into the SRAM framebuffer.
// Optional horizontal mirroring is built when BLIT_FLIP_EN is defined.
//
// state    | meaning
// IDLE     | SRAM owned by drawer, waiting for blitterStart
// GRANT    | took the bus, ackBack pulse
// LOAD     | pop next command, or finish when FIFO empty
// FETCH    | present sprite ROM address
// WRITE    | ROM data valid, write pixel unless transparent/clipped
// STEP     | data hold cycle, advance column/row
// DONE     | bus released, enable pulse
// WAIT_ACK | waiting for drawer to confirm takeover
module sprite_blitter #(
   parameter int          H_RES     = 640,
   parameter int          V_RES     = 480,
   parameter logic [19:0] FB_BASE   = 20'h00000,
   parameter int          CMD_DEPTH = 4,
   parameter logic [15:0] TRANS_KEY = 16'hF81F
) (
   input  logic              Clk,
   input  logic              Reset_N,
   sprite_blitter_if.slave   bus,
   output logic [19:0]       SRAM_ADDR,
   inout  wire  [15:0]       SRAM_DQ,
   output logic              SRAM_WE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_CE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N
);
   localparam int PW = $clog2(CMD_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_GRANT, S_LOAD, S_FETCH, S_WRITE, S_STEP, S_DONE, S_WAIT_ACK
   } state_t;

   typedef struct packed {
`ifdef BLIT_FLIP_EN
      logic        flip;
`endif
      logic [9:0]  x;
      logic [8:0]  y;
      logic [5:0]  w;
      logic [5:0]  h;
      logic [15:0] base;
   } cmd_t;

   state_t      r_state, w_next;
   cmd_t        r_fifo [CMD_DEPTH];
   cmd_t        r_cur, w_in;
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [PW:0] r_count;
   logic [5:0]  r_c, r_r, w_col;
   logic [19:0] r_sram_addr, w_fb_addr;
   logic [15:0] r_dq, w_dq, w_rom_addr;
   logic [10:0] w_px;
   logic [9:0]  w_py;
   logic        w_push, w_pop, w_flip, w_clip, w_skip, w_last, w_own, w_dq_oe;

   assign bus.cmd_ready = (r_count != (PW+1)'(CMD_DEPTH));
   assign w_push = bus.cmd_valid && bus.cmd_ready;
   assign w_pop  = (r_state == S_LOAD) && (r_count != '0);

   always_comb begin
      w_in      = '0;
      w_in.x    = bus.cmd_x;
      w_in.y    = bus.cmd_y;
      w_in.w    = bus.cmd_w;
      w_in.h    = bus.cmd_h;
      w_in.base = bus.cmd_base;
`ifdef BLIT_FLIP_EN
      w_in.flip = bus.cmd_flip;
`endif
   end

`ifdef BLIT_FLIP_EN
   assign w_flip = r_cur.flip;
`else
   assign w_flip = 1'b0;
`endif

   // Mirroring only changes which ROM column is read; destination stays put.
   assign w_col      = w_flip ? (r_cur.w - r_c) : r_c;
   assign w_rom_addr = r_cur.base + 16'(r_r) * (16'(r_cur.w) + 16'd1) + 16'(w_col);
   assign w_px       = 11'(r_cur.x) + 11'(r_c);
   assign w_py       = 10'(r_cur.y) + 10'(r_r);
   assign w_fb_addr  = FB_BASE + 20'(w_py) * 20'(H_RES) + 20'(w_px);
   assign w_clip     = (w_px >= 11'(H_RES)) || (w_py >= 10'(V_RES));
   assign w_skip     = (bus.rom_data == TRANS_KEY) || w_clip;
   assign w_last     = (r_c == r_cur.w) && (r_r == r_cur.h);

   always_ff @(posedge Clk) begin
      if (!Reset_N) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      bus.ackBack   = 1'b0;
      bus.enable    = 1'b0;
      bus.busy      = 1'b0;
      bus.rom_addr  = '0;
      w_own         = 1'b0;
      w_dq_oe       = 1'b0;
      w_dq          = r_dq;
      SRAM_WE_N     = 1'b1;
      SRAM_ADDR     = r_sram_addr;
      case (r_state)
         S_IDLE:     if (bus.blitterStart) w_next = S_GRANT;
         S_GRANT: begin
            bus.ackBack = 1'b1;
            bus.busy    = 1'b1;
            w_own       = 1'b1;
            w_next      = S_LOAD;
         end
         S_LOAD: begin
            bus.busy = 1'b1;
            w_own    = 1'b1;
            w_next   = (r_count == '0) ? S_DONE : S_FETCH;
         end
         S_FETCH: begin
            bus.busy     = 1'b1;
            w_own        = 1'b1;
            bus.rom_addr = w_rom_addr;
            w_next       = S_WRITE;
         end
         S_WRITE: begin
            bus.busy  = 1'b1;
            w_own     = 1'b1;
            w_dq_oe   = 1'b1;
            w_dq      = bus.rom_data;
            SRAM_ADDR = w_fb_addr;
            SRAM_WE_N = w_skip;
            w_next    = S_STEP;
         end
         S_STEP: begin
            bus.busy = 1'b1;
            w_own    = 1'b1;
            w_dq_oe  = 1'b1;
            w_next   = w_last ? S_LOAD : S_FETCH;
         end
         S_DONE: begin
            bus.enable = 1'b1;
            bus.busy   = 1'b1;
            w_next     = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            bus.busy = 1'b1;
            if (bus.acknowladge) w_next = S_IDLE;
         end
         default:    w_next = S_IDLE;
      endcase
   end

   assign SRAM_OE_N = 1'b1;
   assign SRAM_CE_N = !w_own;
   assign SRAM_UB_N = !w_own;
   assign SRAM_LB_N = !w_own;
   assign SRAM_DQ   = w_dq_oe ? w_dq : 16'hzzzz;

   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_c         <= '0;
         r_r         <= '0;
         r_sram_addr <= '0;
         r_dq        <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_in;
            r_wr_ptr         <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_cur    <= r_fifo[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_c      <= '0;
            r_r      <= '0;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: ;
         endcase
         // Address and data are kept through STEP so the write has hold time.
         if (r_state == S_WRITE) begin
            r_sram_addr <= w_fb_addr;
            r_dq        <= bus.rom_data;
         end
         if (r_state == S_STEP) begin
            if (r_c == r_cur.w) begin
               r_c <= '0;
               r_r <= r_r + 6'd1;
            end else begin
               r_c <= r_c + 6'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: expected framebuffer writes come from a
// pixel-list model of each queued sprite, checked against every WE_N pulse.
module tb_sprite_blitter;
   localparam int          H_RES     = 640;
   localparam int          V_RES     = 480;
   localparam logic [19:0] FB_BASE   = 20'h00000;
   localparam logic [15:0] TRANS_KEY = 16'hF81F;

   logic        Clk = 1'b0;
   logic        Reset_N = 1'b0;
   logic [19:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

   sprite_blitter_if bus();

   sprite_blitter #(.H_RES(H_RES), .V_RES(V_RES), .FB_BASE(FB_BASE),
                    .CMD_DEPTH(4), .TRANS_KEY(TRANS_KEY)) dut (
      .Clk(Clk), .Reset_N(Reset_N), .bus(bus.slave),
      .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_WE_N(sram_we_n),
      .SRAM_OE_N(sram_oe_n), .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n),
      .SRAM_LB_N(sram_lb_n)
   );

   always #10 Clk = ~Clk;

   logic [15:0] rom [1024];
   always @(posedge Clk) bus.rom_data <= rom[bus.rom_addr[9:0]];

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_writes = 0;
   int          pend_cost = 0;
   bit          mon_en = 1'b0;
   logic [35:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: the pixels a sprite must produce, in raster order.
   task automatic model_add(input int x, input int y, input int w, input int h,
                            input int base, input bit flip);
      int col, px, py;
      logic [15:0] d;
      bit eff_flip;
`ifdef BLIT_FLIP_EN
      eff_flip = flip;
`else
      eff_flip = 1'b0;
`endif
      for (int r = 0; r <= h; r++)
         for (int c = 0; c <= w; c++) begin
            col = eff_flip ? (w - c) : c;
            d   = rom[(base + r * (w + 1) + col) % 1024];
            px  = x + c;
            py  = y + r;
            if (d != TRANS_KEY && px < H_RES && py < V_RES)
               exp_q.push_back({20'(int'(FB_BASE) + py * H_RES + px), d});
         end
      pend_cost += 3 * (w + 1) * (h + 1) + 1;
   endtask

   task automatic push_cmd(input int x, input int y, input int w, input int h,
                           input int base, input bit flip);
      bit done = 1'b0;
      model_add(x, y, w, h, base, flip);
      @(negedge Clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_x = 10'(x); bus.cmd_y = 9'(y); bus.cmd_w = 6'(w); bus.cmd_h = 6'(h);
      bus.cmd_base = 16'(base); bus.cmd_flip = flip;
      for (int k = 0; k < 300; k++) begin
         if (bus.cmd_ready) begin
            @(negedge Clk);
            done = 1'b1;
            break;
         end
         @(negedge Clk);
      end
      bus.cmd_valid = 1'b0;
      if (!done) chk("push_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_pass(input int ack_delay);
      int en_at = -1;
      @(negedge Clk);
      bus.blitterStart = 1'b1;
      @(negedge Clk);
      bus.blitterStart = 1'b0;
      chk("ackBack_at_t1", 32'(bus.ackBack), 32'd1);
      chk("busy_at_grant", 32'(bus.busy), 32'd1);
      for (int k = 2; k < 5000; k++) begin
         @(negedge Clk);
         if (k == 2) chk("ackBack_one_cycle", 32'(bus.ackBack), 32'd0);
         if (bus.enable) begin
            en_at = k;
            break;
         end
      end
      chk("enable_cycle", 32'(en_at), 32'(3 + pend_cost));
      chk("ce_n_released_done", 32'(sram_ce_n), 32'd1);
      @(negedge Clk);
      chk("enable_one_cycle", 32'(bus.enable), 32'd0);
      repeat (ack_delay) @(negedge Clk);
      chk("busy_until_ack", 32'(bus.busy), 32'd1);
      chk("missing_writes", 32'(exp_q.size()), 32'd0);
      bus.acknowladge = 1'b1;
      @(negedge Clk);
      bus.acknowladge = 1'b0;
      chk("busy_after_ack", 32'(bus.busy), 32'd0);
      pend_cost = 0;
   endtask

   always @(negedge Clk) begin
      logic [35:0] e;
      if (mon_en) begin
         chk("oe_n_never_low", 32'(sram_oe_n), 32'd1);
         if (!sram_we_n) begin
            n_writes++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("[TB] FAIL unexpected_write: addr %0d data %0d, no write expected",
                        sram_addr, sram_dq);
            end else begin
               e = exp_q.pop_front();
               chk("write_addr", 32'(sram_addr), 32'(e[35:16]));
               chk("write_data", 32'(sram_dq), 32'(e[15:0]));
               chk("write_ce_n", 32'(sram_ce_n), 32'd0);
            end
         end
      end
   end

   initial begin
      int w0;
      bool_guard : begin end
      bus.cmd_valid = 0; bus.cmd_x = 0; bus.cmd_y = 0; bus.cmd_w = 0; bus.cmd_h = 0;
      bus.cmd_base = 0; bus.cmd_flip = 0; bus.blitterStart = 0; bus.acknowladge = 0;
      for (int i = 0; i < 1024; i++) rom[i] = 16'(i) ^ 16'h5A00;
      rom[16'h100] = 16'd1; rom[16'h101] = 16'd2; rom[16'h102] = 16'd3; rom[16'h103] = 16'd4;

      repeat (3) @(negedge Clk);
      Reset_N = 1'b1;
      @(negedge Clk);
      chk("rst_ackBack", 32'(bus.ackBack), 32'd0);
      chk("rst_enable", 32'(bus.enable), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
      chk("rst_ub_lb_n", 32'({sram_ub_n, sram_lb_n}), 32'd3);
      chk("rst_sram_addr", 32'(sram_addr), 32'd0);
      chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      mon_en = 1'b1;

      // 2x2 sprite at (10,20)
      push_cmd(10, 20, 1, 1, 16'h100, 1'b0);
      chk("model_len_2x2", 32'(exp_q.size()), 32'd4);
      chk("model_first", 32'(exp_q[0]), 32'({20'd12810, 16'd1}));
      chk("model_last", 32'(exp_q[3]), 32'({20'd13451, 16'd4}));
      chk("model_cost_2x2", 32'(pend_cost), 32'd13);
      w0 = n_writes;
      run_pass(0);
      chk("writes_2x2", 32'(n_writes - w0), 32'd4);

      // transparent pixel skipped
      rom[16'h101] = TRANS_KEY;
      push_cmd(10, 20, 1, 1, 16'h100, 1'b0);
      chk("model_len_trans", 32'(exp_q.size()), 32'd3);
      chk("model_trans_skip", 32'(exp_q[1][35:16]), 32'd13450);
      w0 = n_writes;
      run_pass(1);
      chk("writes_trans", 32'(n_writes - w0), 32'd3);
      rom[16'h101] = 16'd2;

      // right-edge and bottom-edge clipping
      push_cmd(639, 100, 1, 1, 16'h200, 1'b0);
      push_cmd(0, 479, 1, 1, 16'h200, 1'b0);
      chk("model_len_clip", 32'(exp_q.size()), 32'd4);
      chk("model_clip_first", 32'(exp_q[0][35:16]), 32'd64639);
      chk("model_clip_row479", 32'(exp_q[2][35:16]), 32'd306560);
      w0 = n_writes;
      run_pass(0);
      chk("writes_clip", 32'(n_writes - w0), 32'd4);

      // FIFO full: 5th command held, then drawn in the same pass
      for (int i = 0; i < 4; i++) push_cmd(i * 2, 5, 0, 0, 16'h380 + i, 1'b0);
      chk("cmd_ready_full", 32'(bus.cmd_ready), 32'd0);
      w0 = n_writes;
      fork
         push_cmd(8, 5, 0, 0, 16'h384, 1'b0);
         run_pass(0);
      join
      chk("writes_five", 32'(n_writes - w0), 32'd5);

      // empty FIFO pass
      w0 = n_writes;
      run_pass(5);
      chk("writes_empty", 32'(n_writes - w0), 32'd0);

      // reset during WRITE
      push_cmd(0, 0, 3, 3, 16'h300, 1'b0);
      @(negedge Clk);
      bus.blitterStart = 1'b1;
      @(negedge Clk);
      bus.blitterStart = 1'b0;
      begin
         bit hit = 1'b0;
         for (int k = 0; k < 20; k++) begin
            if (!sram_we_n) begin
               hit = 1'b1;
               break;
            end
            @(negedge Clk);
         end
         chk("reset_test_write_seen", 32'(hit), 32'd1);
      end
      #1;
      Reset_N = 1'b0;
      exp_q.delete();
      pend_cost = 0;
      @(negedge Clk);
      chk("midrst_we_n", 32'(sram_we_n), 32'd1);
      chk("midrst_ce_n", 32'(sram_ce_n), 32'd1);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("midrst_sram_addr", 32'(sram_addr), 32'd0);
      Reset_N = 1'b1;
      w0 = n_writes;
      repeat (10) @(negedge Clk);
      chk("midrst_no_writes", 32'(n_writes - w0), 32'd0);

`ifdef BLIT_FLIP_EN
      push_cmd(10, 20, 1, 1, 16'h100, 1'b1);
      chk("flip_model_first", 32'(exp_q[0]), 32'({20'd12810, 16'd2}));
      chk("flip_model_second", 32'(exp_q[1]), 32'({20'd12811, 16'd1}));
      run_pass(0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not finish, limit 2000000");
      $fatal(1);
   end
endmodule
